// File: rtl/candy_avb_pio_bidir.sv
// -----------------------------------------------------------------------------
// candy_avb_pio_bidir
//
// Avalon-MM slave general-purpose I/O port, WIDTH bits wide. It provides
// per-bit direction, optional open-drain drive, atomic set/clear of the output
// register, synchronised pad inputs and edge capture with a maskable,
// level-sensitive interrupt.
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-high
//   address    register word address (0..7)
//   chipselect slave select
//   write_n    write strobe, active-low
//   writedata  write data (bits above WIDTH are ignored)
//   readdata   read data, combinational from address (bits above WIDTH are 0)
//   pad_in     raw pad input, asynchronous to clk
//   pad_out    pad output value
//   pad_oe     pad output enable, 1 = drive
//   irq        interrupt request, active-high level
//
// Register map (word address):
//   0 DATA      read synchronised input, write loads the output register
//   1 DIR       read/write direction, 1 = output
//   2 IRQ_MASK  read/write
//   3 EDGE_CAP  read capture bits, write-1-to-clear
//   4 OUTSET    write ORs into the output register, reads 0
//   5 OUTCLR    write clears bits of the output register, reads 0
//   6,7         reserved, read 0
// -----------------------------------------------------------------------------
module candy_avb_pio_bidir #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0,
   parameter bit               OPEN_DRAIN  = 1'b1,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] pad_in,
   output logic [WIDTH-1:0] pad_out,
   output logic [WIDTH-1:0] pad_oe,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_DIR    = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   // Edge detection is held off until the synchroniser and the previous-value
   // flop both hold genuine pad samples.
   localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] data_out_reg, data_out_next;
   logic [WIDTH-1:0] dir_reg, dir_next;
   logic [WIDTH-1:0] irq_mask_reg, irq_mask_next;
   logic [WIDTH-1:0] edge_cap_reg, edge_cap_next;
   logic             irq_reg;
   logic [2:0]       warm_cnt_reg;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
   logic [WIDTH-1:0] prev_reg;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] wdata;
   logic             wr_en;
   logic             warm_done;
   logic [31:0]      rd_word;

   // The upper write-data bits are don't-care for narrow ports.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   assign wr_en     = chipselect & ~write_n;
   assign wdata     = writedata[WIDTH-1:0];
   assign sync_in   = sync_reg[SYNC_STAGES-1];
   assign warm_done = (warm_cnt_reg == WARM_MAX);

   // ---------------------------------------------------------------------
   // Input synchroniser, previous-value flop and warm-up counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg     <= '0;
         prev_reg     <= '0;
         warm_cnt_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_in};
         prev_reg <= sync_in;
         if (!warm_done) begin
            warm_cnt_reg <= warm_cnt_reg + 3'd1;
         end
      end
   end

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_det = sync_in & ~prev_reg;
         1:       edge_det = ~sync_in & prev_reg;
         default: edge_det = sync_in ^ prev_reg;
      endcase
   end

   // ---------------------------------------------------------------------
   // Register next-state logic
   // ---------------------------------------------------------------------
   assign clr_mask = (wr_en && (address == ADDR_EDGE)) ? wdata : '0;

   // The set term is ORed in after the clear, so a new edge wins over a
   // simultaneous write-1-to-clear of the same bit.
   assign edge_cap_next = (edge_cap_reg & ~clr_mask) | (warm_done ? edge_det : '0);

   always_comb begin
      data_out_next = data_out_reg;
      dir_next      = dir_reg;
      irq_mask_next = irq_mask_reg;
      if (wr_en) begin
         case (address)
            ADDR_DATA:   data_out_next = wdata;
            ADDR_DIR:    dir_next      = wdata;
            ADDR_MASK:   irq_mask_next = wdata;
            ADDR_OUTSET: data_out_next = data_out_reg | wdata;
            ADDR_OUTCLR: data_out_next = data_out_reg & ~wdata;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_reg <= RESET_VALUE;
         dir_reg      <= RESET_DIR;
         irq_mask_reg <= '0;
         edge_cap_reg <= '0;
         irq_reg      <= 1'b0;
      end else begin
         data_out_reg <= data_out_next;
         dir_reg      <= dir_next;
         irq_mask_reg <= irq_mask_next;
         edge_cap_reg <= edge_cap_next;
         irq_reg      <= |(edge_cap_reg & irq_mask_reg);
      end
   end

   // ---------------------------------------------------------------------
   // Read mux (no side effects) and pad drive
   // ---------------------------------------------------------------------
   always_comb begin
      rd_word = '0;
      case (address)
         ADDR_DATA: rd_word[WIDTH-1:0] = sync_in;
         ADDR_DIR:  rd_word[WIDTH-1:0] = dir_reg;
         ADDR_MASK: rd_word[WIDTH-1:0] = irq_mask_reg;
         ADDR_EDGE: rd_word[WIDTH-1:0] = edge_cap_reg;
         default:   rd_word = '0;
      endcase
   end

   assign readdata = rd_word;

   // Open-drain pins only ever drive low; a 1 in data_out releases the pin.
   assign pad_out = OPEN_DRAIN ? '0 : data_out_reg;
   assign pad_oe  = OPEN_DRAIN ? (dir_reg & ~data_out_reg) : dir_reg;
   assign irq     = irq_reg;

endmodule

// File: tb/tb_candy_avb_pio_bidir.sv
// -----------------------------------------------------------------------------
// tb_candy_avb_pio_bidir
//
// Three instances share one bus and pad stimulus: an 8-bit open-drain port, an
// 8-bit push-pull port and a 1-bit push-pull port. A behavioural model built
// from the pad-sample history predicts every output on every cycle; directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_candy_avb_pio_bidir;

   localparam int S    = 2;    // synchroniser depth used by all instances
   localparam int HMAX = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  pad_in;

   logic [31:0] rd_od, rd_pp, rd_w1;
   logic [7:0]  out_od, oe_od, out_pp, oe_pp;
   logic [0:0]  out_w1, oe_w1;
   logic        irq_od, irq_pp, irq_w1;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   candy_avb_pio_bidir #(
      .WIDTH(8), .RESET_VALUE(8'h00), .RESET_DIR(8'h00),
      .OPEN_DRAIN(1'b1), .SYNC_STAGES(S), .EDGE_TYPE(0)
   ) u_od (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_od),
      .pad_in(pad_in), .pad_out(out_od), .pad_oe(oe_od), .irq(irq_od)
   );

   candy_avb_pio_bidir #(
      .WIDTH(8), .RESET_VALUE(8'h00), .RESET_DIR(8'h00),
      .OPEN_DRAIN(1'b0), .SYNC_STAGES(S), .EDGE_TYPE(0)
   ) u_pp (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_pp),
      .pad_in(pad_in), .pad_out(out_pp), .pad_oe(oe_pp), .irq(irq_pp)
   );

   candy_avb_pio_bidir #(
      .WIDTH(1), .RESET_VALUE(1'b0), .RESET_DIR(1'b0),
      .OPEN_DRAIN(1'b0), .SYNC_STAGES(S), .EDGE_TYPE(0)
   ) u_w1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_w1),
      .pad_in(pad_in[0:0]), .pad_out(out_w1), .pad_oe(oe_w1), .irq(irq_w1)
   );

   // ---------------------------------------------------------------------
   // Behavioural model. Every register op is bitwise, so the 1-bit port is
   // bit 0 of the 8-bit model (only its irq needs its own term).
   // ---------------------------------------------------------------------
   logic [7:0] pad_hist [HMAX];
   int         e_cnt    = 0;   // number of clock edges seen
   int         last_rst = 0;   // edge index of the latest reset edge
   logic [7:0] m_data, m_dir, m_mask, m_cap;
   logic       m_irq, m_irq1;
   logic [7:0] m_s, m_p, m_det, m_clr, m_wd;
   logic       m_warm, m_wr;

   // Pad value sampled at edge i; anything sampled at or before a reset edge
   // has been flushed and reads as 0.
   function automatic logic [7:0] hist(input int i);
      if (i <= last_rst || i >= HMAX) return 8'h00;
      return pad_hist[i];
   endfunction

   initial begin
      m_data = 8'h00; m_dir = 8'h00; m_mask = 8'h00; m_cap = 8'h00;
      m_irq = 1'b0; m_irq1 = 1'b0;
      forever begin
         @(posedge clk);
         e_cnt = e_cnt + 1;
         if (reset) begin
            m_data = 8'h00; m_dir = 8'h00; m_mask = 8'h00; m_cap = 8'h00;
            m_irq = 1'b0; m_irq1 = 1'b0;
            last_rst = e_cnt;
         end else begin
            if (e_cnt < HMAX) pad_hist[e_cnt] = pad_in;
            // Synchronised value and its predecessor as they stood before this edge.
            m_s    = hist(e_cnt - S);
            m_p    = hist(e_cnt - S - 1);
            m_det  = m_s & ~m_p;
            m_warm = ((e_cnt - 1 - last_rst) >= S + 1);
            m_irq  = |(m_cap & m_mask);
            m_irq1 = m_cap[0] & m_mask[0];
            m_wr   = chipselect & ~write_n;
            m_wd   = writedata[7:0];
            m_clr  = (m_wr && address == 3'd3) ? m_wd : 8'h00;
            m_cap  = (m_cap & ~m_clr) | (m_warm ? m_det : 8'h00);
            if (m_wr) begin
               case (address)
                  3'd0: m_data = m_wd;
                  3'd1: m_dir  = m_wd;
                  3'd2: m_mask = m_wd;
                  3'd4: m_data = m_data | m_wd;
                  3'd5: m_data = m_data & ~m_wd;
                  default: ;
               endcase
            end
         end
      end
   end

   function automatic logic [7:0] exp_rd8(input logic [2:0] a);
      case (a)
         3'd0:    return hist(e_cnt - S + 1);
         3'd1:    return m_dir;
         3'd2:    return m_mask;
         3'd3:    return m_cap;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      logic [7:0] er;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            er = exp_rd8(address);
            chk("m_rd_od", rd_od, 32'(er));
            chk("m_rd_pp", rd_pp, 32'(er));
            chk("m_rd_w1", rd_w1, 32'(er[0]));
            chk("m_out_od", 32'(out_od), 32'h0);
            chk("m_oe_od", 32'(oe_od), 32'(m_dir & ~m_data));
            chk("m_out_pp", 32'(out_pp), 32'(m_data));
            chk("m_oe_pp", 32'(oe_pp), 32'(m_dir));
            chk("m_out_w1", 32'(out_w1), 32'(m_data[0]));
            chk("m_oe_w1", 32'(oe_w1), 32'(m_dir[0]));
            chk("m_irq_od", 32'(irq_od), 32'(m_irq));
            chk("m_irq_pp", 32'(irq_pp), 32'(m_irq));
            chk("m_irq_w1", 32'(irq_w1), 32'(m_irq1));
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed stimulus. Tasks start and end 2 time units after a rising edge.
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #2;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      address = a;
      #1;
      chk(name, rd_od, exp);
   endtask

   initial begin
      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; pad_in = 8'h00;
      repeat (3) tick();
      chk_en = 1'b1;
      reset  = 1'b0;

      // Reset state
      rd(3'd1, 32'h0, "rst_dir");
      rd(3'd3, 32'h0, "rst_cap");
      chk("rst_oe", 32'(oe_od), 32'h0);
      chk("rst_irq", 32'(irq_od), 32'h0);

      // Output drive, set and clear
      wr(3'd1, 32'hFF);
      wr(3'd0, 32'hA5);
      chk("od_oe_a5", 32'(oe_od), 32'h5A);
      chk("od_out_a5", 32'(out_od), 32'h00);
      chk("w1_out_a5", 32'(out_w1), 32'h1);
      wr(3'd4, 32'h0F);
      chk("od_oe_set", 32'(oe_od), 32'h50);
      chk("pp_out_set", 32'(out_pp), 32'hAF);
      wr(3'd5, 32'h81);
      chk("pp_out_clr", 32'(out_pp), 32'h2E);
      chk("od_oe_clr", 32'(oe_od), 32'hD1);
      chk("w1_out_clr", 32'(out_w1), 32'h0);

      // Input latency: capture at N+3, irq at N+4
      wr(3'd2, 32'h01);
      address = 3'd3;
      pad_in  = 8'h01;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("lat_cap", rd_od, (i >= 3) ? 32'h1 : 32'h0);
         chk("lat_irq", 32'(irq_od), (i >= 4) ? 32'h1 : 32'h0);
      end
      address = 3'd0;
      pad_in  = 8'h03;
      tick();
      chk("lat_data1", rd_od, 32'h01);
      tick();
      chk("lat_data2", rd_od, 32'h03);
      tick();
      tick();
      rd(3'd3, 32'h03, "cap_03");

      // Set wins over write-1-to-clear on the same cycle
      wr(3'd2, 32'hFF);
      pad_in = 8'h02;
      repeat (4) tick();
      pad_in = 8'h03;
      tick();
      tick();
      wr(3'd3, 32'h01);
      rd(3'd3, 32'h03, "set_wins");
      wr(3'd3, 32'h01);
      rd(3'd3, 32'h02, "clr_bit0");
      chk("irq_held", 32'(irq_od), 32'h1);
      wr(3'd3, 32'h02);
      rd(3'd3, 32'h00, "clr_bit1");
      chk("irq_lag", 32'(irq_od), 32'h1);
      tick();
      chk("irq_drop", 32'(irq_od), 32'h0);

      // Reserved addresses and set/clear registers read 0; reserved writes ignored
      wr(3'd6, 32'h00);
      wr(3'd7, 32'h00);
      rd(3'd1, 32'hFF, "dir_kept");
      rd(3'd4, 32'h0, "rd_outset");
      rd(3'd5, 32'h0, "rd_outclr");
      rd(3'd6, 32'h0, "rd_res6");
      rd(3'd7, 32'h0, "rd_res7");

      // Upper write bits ignored, upper read bits zero
      wr(3'd4, 32'h1);
      chk("w1_out_set", 32'(out_w1), 32'h1);
      wr(3'd0, 32'hFFFFFFFE);
      chk("w1_out_fe", 32'(out_w1), 32'h0);
      chk("pp_out_fe", 32'(out_pp), 32'hFE);
      wr(3'd1, 32'hFFFFFF00);
      chk("pp_oe_hi", 32'(oe_pp), 32'h00);
      wr(3'd1, 32'hFFFFFFFF);
      wr(3'd2, 32'hFFFFFFFF);
      pad_in = 8'hFF;
      repeat (3) tick();
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         chk("w1_hi_zero", {1'b0, rd_w1[31:1]}, 32'h0);
         chk("od_hi_zero", {8'h00, rd_od[31:8]}, 32'h0);
      end

      // Pads held high through reset: no false edge during warm-up
      reset = 1'b1;
      tick();
      chk("rst_mid_oe", 32'(oe_od), 32'h00);
      chk("rst_mid_irq", 32'(irq_od), 32'h0);
      tick();
      reset = 1'b0;
      wr(3'd2, 32'hFF);
      address = 3'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("warm_cap", rd_od, 32'h0);
         chk("warm_irq", 32'(irq_od), 32'h0);
      end
      pad_in = 8'h00;
      repeat (4) tick();
      pad_in = 8'h01;
      repeat (4) tick();
      rd(3'd3, 32'h01, "post_warm_cap");

      tick();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
